// File: rtl/sim_exit_reporter.sv
// sim_exit_reporter
// Simulation-control responder on the core data bus. Core software writes an
// exit code and console bytes here. The bench sees done/exit_code/timeout and
// a console byte stream. A watchdog raises timeout when the decode-stage PC
// stops moving.
//
// Register map (word index = req_addr[3:2]):
//   0 EXIT    W: the first write latches exit_code and sets done. R: exit_code
//   1 CONSOLE W: pushes wdata[7:0] into the console FIFO.      R: 0
//   2 STATUS  R: {timeout,done,fifo_full,fifo_empty} in [3:0], count in [15:8]
//   3 CYCLE   R: free-running cycle counter
module sim_exit_reporter #(
  parameter int FIFO_DEPTH = 16,
  parameter int WDT_LIMIT  = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        done,
  output logic [31:0] exit_code,
  output logic        timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WDT_W = $clog2(WDT_LIMIT + 1);

  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [WDT_W-1:0] WDT_MAX       = WDT_W'(WDT_LIMIT);

  localparam logic [1:0] REG_EXIT    = 2'd0;
  localparam logic [1:0] REG_CONSOLE = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CYCLE   = 2'd3;

  // Response channel: one transaction can be outstanding at a time.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } rsp_state_t;

  rsp_state_t state;
  rsp_state_t state_next;

  // Bus decode
  logic [1:0]        word;
  logic              console_stall;
  logic              accept;
  logic              push;
  logic              pop;
  logic [31:0]       read_data;
  logic [31:0]       status_word;

  // Console FIFO
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;

  // Free-running cycle counter and PC watchdog
  logic [31:0]       cycle_cnt;
  logic [31:0]       prev_pc;
  logic [WDT_W-1:0]  wdt_cnt;
  logic [WDT_W-1:0]  wdt_next;
  logic              pc_held;

  // The byte-lane bits of the address carry no meaning for word registers.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  assign word       = req_addr[3:2];
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);

  // A console write that finds the FIFO full waits instead of being dropped.
  assign console_stall = req_valid && req_wen && (word == REG_CONSOLE) && fifo_full;
  assign accept        = req_valid && req_ready;
  assign push          = accept && req_wen && (word == REG_CONSOLE);
  assign pop           = tx_valid && tx_ready;

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  // Response state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Response next state: leave IDLE on acceptance, return once the response is taken.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_RESP;
      S_RESP: if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs: no new request while a response is pending or a console push must wait.
  always_comb begin
    rsp_valid = (state == S_RESP);
    req_ready = (state == S_IDLE) && !console_stall;
  end

  // STATUS word assembly.
  always_comb begin
    status_word                = '0;
    status_word[3:0]           = {timeout, done, fifo_full, fifo_empty};
    status_word[8 +: CNT_W]    = fifo_cnt;
  end

  // Read mux; the value is captured at acceptance so CYCLE reflects the accept cycle.
  always_comb begin
    read_data = '0;
    case (word)
      REG_EXIT:   read_data = exit_code;
      REG_STATUS: read_data = status_word;
      REG_CYCLE:  read_data = cycle_cnt;
      default:    read_data = '0;
    endcase
  end

  // Response data: loaded at acceptance and held until the next accepted request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
    end else if (accept) begin
      rsp_rdata <= req_wen ? 32'h0 : read_data;
    end
  end

  // Exit code: only the first EXIT write counts; done is sticky until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      exit_code <= '0;
    end else if (accept && req_wen && (word == REG_EXIT) && !done) begin
      done      <= 1'b1;
      exit_code <= req_wdata;
    end
  end

  // FIFO storage: payload only, so it carries no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= req_wdata[7:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Cycle counter: counts every cycle since reset and wraps at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // A cycle counts toward the watchdog only when a valid PC repeats before done.
  assign pc_held = pc_valid && (pc == prev_pc) && !done;

  // Watchdog count update: clears on any movement, saturates at the limit.
  always_comb begin
    wdt_next = '0;
    if (pc_held) begin
      wdt_next = (wdt_cnt == WDT_MAX) ? wdt_cnt : wdt_cnt + 1'b1;
    end
  end

  // Watchdog state: timeout rises on the edge the count reaches the limit and sticks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_pc <= '0;
      wdt_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (pc_valid) prev_pc <= pc;
      wdt_cnt <= wdt_next;
      if (wdt_next == WDT_MAX) timeout <= 1'b1;
    end
  end

endmodule
